// File: rtl/tmc_spi_responder_if.sv
// SPI pin bundle plus write-commit/frame-error report for the TMC-style responder.
// The master side drives the SPI pins; the slave side (the responder) drives MISO and the reports.
`timescale 1ns/1ps
interface tmc_spi_responder_if;
    logic        spi_clk;
    logic        spi_cs;
    logic        mosi;
    logic        miso;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;

    modport master (
        output spi_clk, spi_cs, mosi,
        input  miso, wr_valid, wr_addr, wr_data, frame_err
    );

    modport slave (
        input  spi_clk, spi_cs, mosi,
        output miso, wr_valid, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/tmc_spi_responder.sv
// TMC-style 40-bit SPI mode-3 responder: oversampled pins, local register file,
// status byte plus pipelined read data returned on MISO.
`timescale 1ns/1ps
module tmc_spi_responder #(
    parameter int REG_NUM     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] status_i,
    tmc_spi_responder_if.slave spi
);
    localparam int         AW        = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [7:0] REG_LIMIT = 8'(REG_NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic                   sck_fall_q;
    logic                   sck_rise_q;
    logic                   cs_fall_q;
    logic                   cs_rise_q;
    logic                   armed_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // flush_q fills with ones after reset so the idle reset values of the
    // synchronizers can never be mistaken for a genuinely observed CS-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sck_prev_q  <= 1'b1;
            cs_prev_q   <= 1'b1;
            sck_fall_q  <= 1'b0;
            sck_rise_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sck_sync_q[i]  <= sck_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sck_sync_q[0]  <= spi.spi_clk;
            cs_sync_q[0]   <= spi.spi_cs;
            mosi_sync_q[0] <= spi.mosi;
            flush_q        <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            sck_prev_q     <= sck_s;
            cs_prev_q      <= cs_s;
            sck_fall_q     <= sck_prev_q & ~sck_s;
            sck_rise_q     <= ~sck_prev_q & sck_s;
            cs_fall_q      <= cs_prev_q & ~cs_s;
            cs_rise_q      <= ~cs_prev_q & cs_s;
            if (flush_q[SYNC_STAGES] && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    state_t      state_q;
    logic [39:0] tx_sh_q;
    logic [39:0] rx_sh_q;
    logic [5:0]  bit_cnt_q;
    logic        miso_q;
    logic [31:0] rd_pipe_q;
    logic        wr_valid_q;
    logic [6:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic        frame_err_q;
    logic [31:0] reg_q [REG_NUM];

    logic          rx_write;
    logic [6:0]    rx_addr;
    logic [AW-1:0] rx_idx;
    logic          rx_in_range;

    assign rx_write    = rx_sh_q[39];
    assign rx_addr     = rx_sh_q[38:32];
    assign rx_idx      = rx_addr[AW-1:0];
    assign rx_in_range = ({1'b0, rx_addr} < REG_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            rd_pipe_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall_q && armed_q) begin
                        state_q   <= ST_SHIFT;
                        tx_sh_q   <= {status_i, rd_pipe_q};
                        bit_cnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_q) begin
                        state_q <= ST_COMMIT;
                        miso_q  <= 1'b0;
                        if (bit_cnt_q == 6'd40) begin
                            if (rx_write) begin
                                wr_valid_q <= 1'b1;
                                wr_addr_q  <= rx_addr;
                                wr_data_q  <= rx_sh_q[31:0];
                                if (rx_in_range) begin
                                    reg_q[rx_idx] <= rx_sh_q[31:0];
                                end
                            end else begin
                                rd_pipe_q <= rx_in_range ? reg_q[rx_idx] : 32'h0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        if (sck_fall_q) begin
                            miso_q  <= tx_sh_q[39];
                            tx_sh_q <= {tx_sh_q[38:0], 1'b0};
                        end
                        // Counter saturates at 41 so any overlong frame stays distinguishable.
                        if (sck_rise_q) begin
                            rx_sh_q <= {rx_sh_q[38:0], mosi_s};
                            if (bit_cnt_q != 6'd41) begin
                                bit_cnt_q <= bit_cnt_q + 6'd1;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    miso_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    miso_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi.miso      = miso_q;
    assign spi.wr_valid  = wr_valid_q;
    assign spi.wr_addr   = wr_addr_q;
    assign spi.wr_data   = wr_data_q;
    assign spi.frame_err = frame_err_q;
endmodule

// File: tb/tb_tmc_spi_responder.sv
// Bench for tmc_spi_responder: bit-banged SPI mode-3 master with random clk/SCK phase,
// compared against a register-file/read-pipe model of the datagram rules.
`timescale 1ns/1ps
module tb_tmc_spi_responder;
    localparam int HALF = 8;
    localparam int NREG = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] status = 8'h00;

    tmc_spi_responder_if bus();

    tmc_spi_responder #(.REG_NUM(NREG), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .status_i (status),
        .spi      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int phase  = 1;

    // Pulse monitor: counts commit reports and catches any pulse longer than 1 clk.
    int          wr_cnt = 0;
    int          err_cnt = 0;
    int          wide_pulses = 0;
    logic        wr_prev = 1'b0;
    logic        err_prev = 1'b0;
    logic [6:0]  mon_addr = '0;
    logic [31:0] mon_data = '0;

    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            wr_cnt++;
            mon_addr = bus.wr_addr;
            mon_data = bus.wr_data;
            if (wr_prev) wide_pulses++;
        end
        if (bus.frame_err === 1'b1) begin
            err_cnt++;
            if (err_prev) wide_pulses++;
        end
        wr_prev  = (bus.wr_valid === 1'b1);
        err_prev = (bus.frame_err === 1'b1);
    end

    // Reference model: register array plus "last valid read" data.
    logic [31:0] m_reg [0:127];
    logic [31:0] m_pipe;

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) m_reg[i] = 32'h0;
        m_pipe = 32'h0;
    endfunction

    function automatic void model_frame(input logic [39:0] tx, input int nbits,
                                        output logic [39:0] exp_rx, output int exp_wr,
                                        output int exp_err);
        int addr;
        exp_rx  = {status, m_pipe};
        exp_wr  = 0;
        exp_err = 0;
        addr    = int'(tx[38:32]);
        if (nbits != 40) begin
            exp_err = 1;
        end else if (tx[39]) begin
            exp_wr = 1;
            if (addr < NREG) m_reg[addr] = tx[31:0];
        end else begin
            m_pipe = (addr < NREG) ? m_reg[addr] : 32'h0;
        end
    endfunction

    task automatic spi_bits(input logic [39:0] tx, input int nbits, output logic [39:0] rx);
        logic [39:0] sh;
        sh = tx;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_clk = 1'b0;
            bus.mosi    = sh[39];
            sh          = {sh[38:0], 1'b0};
            repeat (HALF) @(posedge clk);
            #(phase);
            if (i < 40) rx = {rx[38:0], bus.miso};
            bus.spi_clk = 1'b1;
            repeat (HALF) @(posedge clk);
            #(phase);
        end
        if (nbits < 40) rx = rx << (40 - nbits);
    endtask

    task automatic spi_frame(input logic [39:0] tx, input int nbits, output logic [39:0] rx,
                             output int nwr, output int nerr);
        int wr0;
        int e0;
        wr0   = wr_cnt;
        e0    = err_cnt;
        phase = $urandom_range(1, 9);
        @(posedge clk);
        #(phase);
        bus.spi_cs = 1'b0;
        repeat (HALF) @(posedge clk);
        #(phase);
        spi_bits(tx, nbits, rx);
        bus.spi_cs = 1'b1;
        bus.mosi   = 1'b0;
        repeat (8) @(posedge clk);
        nwr  = wr_cnt - wr0;
        nerr = err_cnt - e0;
        $display("frame tx=%010h bits=%0d status=%02h rx=%010h wr=%0d err=%0d",
                 tx, nbits, status, rx, nwr, nerr);
    endtask

    logic [39:0] rx;
    logic [39:0] exp_rx;
    int          nwr;
    int          nerr;
    int          exp_wr;
    int          exp_err;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
        checks++;
        if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", bus.wr_valid); end
        checks++;
        if (bus.wr_addr !== 7'h0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", bus.wr_addr); end
        checks++;
        if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", bus.wr_data); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        repeat (10) @(posedge clk);
    endtask

    task automatic test_first_reply();
        logic [39:0] tx;
        status = 8'($urandom);
        tx = {1'b0, 7'($urandom_range(0, NREG - 1)), 32'h0};
        model_frame(tx, 40, exp_rx, exp_wr, exp_err);
        spi_frame(tx, 40, rx, nwr, nerr);
        checks++;
        if (rx !== exp_rx) begin errors++; $display("FAIL first_reply: got %010h expected %010h", rx, exp_rx); end
    endtask

    task automatic test_write_read();
        status = 8'h3C;
        model_frame(40'h85_DEADBEEF, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h85_DEADBEEF, 40, rx, nwr, nerr);
        checks++;
        if (nwr !== 1 || nerr !== 0) begin errors++; $display("FAIL write_pulse: got wr=%0d err=%0d expected wr=1 err=0", nwr, nerr); end
        checks++;
        if (mon_addr !== 7'h05) begin errors++; $display("FAIL write_addr: got %h expected 05", mon_addr); end
        checks++;
        if (mon_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h expected deadbeef", mon_data); end
        checks++;
        if (rx !== exp_rx) begin errors++; $display("FAIL write_reply: got %010h expected %010h", rx, exp_rx); end
        model_frame(40'h05_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h05_00000000, 40, rx, nwr, nerr);
        model_frame(40'h00_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h00_00000000, 40, rx, nwr, nerr);
        checks++;
        if (rx[31:0] !== 32'hDEADBEEF || rx !== exp_rx) begin
            errors++; $display("FAIL read_back: got %010h expected %010h", rx, exp_rx);
        end
    endtask

    task automatic test_status();
        status = 8'hA5;
        model_frame(40'h03_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h03_00000000, 40, rx, nwr, nerr);
        checks++;
        if (rx[39:32] !== 8'hA5 || rx !== exp_rx) begin
            errors++; $display("FAIL status_byte: got %010h expected %010h", rx, exp_rx);
        end
    endtask

    task automatic test_abort();
        logic [39:0] mask;
        logic [39:0] ones;
        ones = '1;
        mask = ones << 17;
        model_frame(40'h85_11111111, 23, exp_rx, exp_wr, exp_err);
        spi_frame(40'h85_11111111, 23, rx, nwr, nerr);
        checks++;
        if (nerr !== 1 || nwr !== 0) begin errors++; $display("FAIL abort23_pulses: got wr=%0d err=%0d expected wr=0 err=1", nwr, nerr); end
        checks++;
        if ((rx & mask) !== (exp_rx & mask)) begin errors++; $display("FAIL abort23_reply: got %010h expected %010h", rx & mask, exp_rx & mask); end
        model_frame(40'h05_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h05_00000000, 40, rx, nwr, nerr);
        model_frame(40'h00_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h00_00000000, 40, rx, nwr, nerr);
        checks++;
        if (rx[31:0] !== 32'hDEADBEEF || rx !== exp_rx) begin
            errors++; $display("FAIL abort_prior_value: got %010h expected %010h", rx, exp_rx);
        end
        model_frame(40'h85_22222222, 41, exp_rx, exp_wr, exp_err);
        spi_frame(40'h85_22222222, 41, rx, nwr, nerr);
        checks++;
        if (nerr !== 1 || nwr !== 0) begin errors++; $display("FAIL abort41_pulses: got wr=%0d err=%0d expected wr=0 err=1", nwr, nerr); end
    endtask

    task automatic test_out_of_range();
        model_frame(40'h90_12345678, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h90_12345678, 40, rx, nwr, nerr);
        checks++;
        if (nwr !== 1 || mon_addr !== 7'h10 || mon_data !== 32'h12345678) begin
            errors++; $display("FAIL oor_write: got wr=%0d addr=%h data=%h expected wr=1 addr=10 data=12345678", nwr, mon_addr, mon_data);
        end
        model_frame(40'h10_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h10_00000000, 40, rx, nwr, nerr);
        model_frame(40'h00_00000000, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h00_00000000, 40, rx, nwr, nerr);
        checks++;
        if (rx[31:0] !== 32'h0 || rx !== exp_rx) begin
            errors++; $display("FAIL oor_read: got %010h expected %010h", rx, exp_rx);
        end
    endtask

    task automatic test_reset_cs_low();
        int wr0;
        int e0;
        logic [39:0] junk;
        phase = $urandom_range(1, 9);
        @(posedge clk);
        #(phase);
        bus.spi_cs = 1'b0;
        repeat (HALF) @(posedge clk);
        #(phase);
        spi_bits(40'h87_CAFEF00D, 10, junk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #(phase);
        rst_n = 1'b1;
        model_reset();
        wr0 = wr_cnt;
        e0  = err_cnt;
        repeat (6) @(posedge clk);
        #(phase);
        spi_bits(40'h87_CAFEF00D, 40, junk);
        bus.spi_cs = 1'b1;
        bus.mosi   = 1'b0;
        repeat (10) @(posedge clk);
        $display("frame tx=87cafef00d bits=40 held-low-through-reset wr=%0d err=%0d", wr_cnt - wr0, err_cnt - e0);
        checks++;
        if (wr_cnt - wr0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL reset_cs_low: got wr=%0d err=%0d expected 0 0", wr_cnt - wr0, err_cnt - e0);
        end
        model_frame(40'h87_0BADF00D, 40, exp_rx, exp_wr, exp_err);
        spi_frame(40'h87_0BADF00D, 40, rx, nwr, nerr);
        checks++;
        if (nwr !== 1 || mon_data !== 32'h0BADF00D || rx !== exp_rx) begin
            errors++; $display("FAIL after_reset_frame: got wr=%0d data=%h rx=%010h expected wr=1 data=0badf00d rx=%010h", nwr, mon_data, rx, exp_rx);
        end
    endtask

    task automatic test_random_speed();
        logic [39:0] tx;
        logic [39:0] mask;
        logic [39:0] ones;
        int          nb;
        ones = '1;
        for (int f = 0; f < 100; f++) begin
            status = 8'($urandom);
            tx = {1'($urandom), 7'($urandom_range(0, 20)), 32'($urandom)};
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 41) : 40;
            mask = (nb >= 40) ? ones : (ones << (40 - nb));
            model_frame(tx, nb, exp_rx, exp_wr, exp_err);
            spi_frame(tx, nb, rx, nwr, nerr);
            checks++;
            if ((rx & mask) !== (exp_rx & mask)) begin
                errors++; $display("FAIL rand_reply[%0d]: got %010h expected %010h", f, rx & mask, exp_rx & mask);
            end
            checks++;
            if (nwr !== exp_wr || nerr !== exp_err) begin
                errors++; $display("FAIL rand_pulses[%0d]: got wr=%0d err=%0d expected wr=%0d err=%0d", f, nwr, nerr, exp_wr, exp_err);
            end
            if (exp_wr == 1) begin
                checks++;
                if (mon_addr !== tx[38:32] || mon_data !== tx[31:0]) begin
                    errors++; $display("FAIL rand_write[%0d]: got %h/%h expected %h/%h", f, mon_addr, mon_data, tx[38:32], tx[31:0]);
                end
            end
        end
    endtask

    task automatic test_pulse_width();
        checks++;
        if (wide_pulses !== 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", wide_pulses); end
    endtask

    initial begin
        bus.spi_clk = 1'b1;
        bus.spi_cs  = 1'b1;
        bus.mosi    = 1'b0;
        model_reset();
        test_reset();
        test_first_reply();
        test_write_read();
        test_status();
        test_abort();
        test_out_of_range();
        test_reset_cs_low();
        test_random_speed();
        test_pulse_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tmc_spi_responder.md
# tmc_spi_responder

SPI responder (slave) that models the TMC-style 40-bit register datagram seen by the motor driver. The on-chip TMC SPI initiator drives it in loopback simulation and on the test fixture. It decodes write/read datagrams into a local register file and returns a status byte plus pipelined read data on MISO. All SPI pins are asynchronous to `clk` and are oversampled.

## Interface
- `REG_NUM`, 16: number of implemented 32-bit registers, addresses 0..REG_NUM-1, at most 128.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_clk`, `spi_cs` and `mosi`.
- `clk` input 1: system clock, 100 MHz nominal. Single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `spi_clk` input 1: SPI clock, mode 3 (CPOL=1, CPHA=1), idle high.
- `spi_cs` input 1: chip select, active low.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first.
- `status_i` input 8: status byte returned in bits 39..32 of every reply.
- `wr_valid` output 1: one-cycle pulse when a valid write datagram commits.
- `wr_addr` output 7: address of the committed write.
- `wr_data` output 32: data of the committed write.
- `frame_err` output 1: one-cycle pulse when a datagram is aborted or malformed.

## Operation
- Datagram: 40 bits, MSB first. Bit 39 = W (1 write, 0 read), bits 38..32 = address, bits 31..0 = data.
- Synchronizers reset to idle (`spi_clk`=1, `spi_cs`=1, `mosi`=0). Edge detection uses the last synchronized stage against one extra register.
- `armed` flag: cleared by reset, set when synchronized CS is high. A CS falling edge starts a frame only if `armed`=1. A CS held low through reset release therefore starts no frame.
- States:
  - IDLE: waiting for a CS fall.
  - SHIFT: CS low, counting bits.
  - COMMIT: one cycle, entered on a CS rise from SHIFT.
  - Return to IDLE after COMMIT.
- IDLE→SHIFT on a detected CS fall:
  - Load `tx_sh` <= {status_i, rd_pipe}.
  - Clear `bit_cnt`.
- SHIFT, detected SCK falling edge: `miso` <= `tx_sh[39]`, then `tx_sh` shifts left one bit, filling with 0.
- SHIFT, detected SCK rising edge:
  - `rx_sh` <= {rx_sh[38:0], mosi_sync}.
  - `bit_cnt` increments, saturating at 41.
- SHIFT→COMMIT on a detected CS rise.
  - If `bit_cnt`==40 and W=1:
    - Pulse `wr_valid` and update `wr_addr`/`wr_data`.
    - If address < REG_NUM, write `reg[addr]`.
  - If `bit_cnt`==40 and W=0: `rd_pipe` <= (addr < REG_NUM) ? reg[addr] : 0.
  - If `bit_cnt`!=40: pulse `frame_err`. No register, `rd_pipe` or `wr_*` change.
- Writes never update `rd_pipe`. A reply always carries the data of the most recent valid read, as on TMC parts.
- Writes to address ≥ REG_NUM still pulse `wr_valid`, but store nothing.
- `miso` is forced to 0 when CS is high (IDLE/COMMIT). No tri-state.

## Timing
- Reset values:
  - `miso`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `frame_err`=0.
  - All `reg[]`=0, `rd_pipe`=0, `armed`=0, state IDLE.
- Pin-to-detected-edge latency is SYNC_STAGES+1 clk.
- `miso` updates SYNC_STAGES+2 clk after the SCK falling pin edge. With defaults that is 4 clk, or 40 ns at 100 MHz.
- Requirement: each SCK half period ≥ 8 clk, i.e. SCK ≤ 6.25 MHz at 100 MHz.
- `wr_valid`/`frame_err` assert 1 clk after the detected CS rise (COMMIT cycle) and last exactly 1 clk.
- `rd_pipe` is valid at the COMMIT cycle. A CS fall detected in the same cycle as COMMIT is impossible given the CS-high minimum of 2 clk. The spec requires CS high ≥ 4 clk between frames.
- `status_i` is sampled only at the CS-fall detection cycle.
- Reset mid-frame: immediate asynchronous clear. The partial frame is discarded without `frame_err`. No new frame starts until CS has been seen high.

## Test plan
- Write then read:
  - Send write 0x85_DEADBEEF: expect `wr_valid` 1 clk, `wr_addr`=0x05, `wr_data`=0xDEADBEEF.
  - Send read 0x05_00000000, then read 0x00_00000000: expect the second reply bits 31..0 = 0xDEADBEEF.
- Status and pipelining: with `status_i`=0xA5, any frame returns 0xA5 in bits 39..32. After reset, the first reply data is 0x00000000.
- Aborted frame: raise CS after 23 bits → `frame_err` 1 clk, `wr_valid` stays 0. A following read of the targeted address returns the prior value. Repeat with a 41-bit frame → `frame_err`.
- Out-of-range: write 0x90_12345678 (addr 16 ≥ REG_NUM) → `wr_valid` with `wr_addr`=0x10. A read of addr 16 followed by any frame returns 0x00000000.
- Reset with CS low: assert `rst_n`=0 mid-frame while holding CS low, release, then clock 40 bits → no `wr_valid`, no `frame_err`. The next full frame after CS goes high works normally.
- Speed margin: SCK half period = 8 clk with random `clk`/SCK phase → all 40 MISO bits are stable at the SCK rising edges across 100 frames.
